// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with KMP-style fallback,
// overlap/non-overlap matching and a saturating match counter.
module seq_detect_prog #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             q_valid,
  input  logic             q,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic [LEN_W-1:0] progress,
  output logic             cfg_err
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [LEN_W-1:0] s_q, s_d;
  logic             out_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  logic [PAT_W-1:0] pb;
  logic [LEN_W-1:0] cand, border;
  logic             err, accept, match;

  function automatic logic pbit(input logic [PAT_W-1:0] v, input int idx);
    return (idx >= 0 && idx < PAT_W) ? v[IDX_W'(idx)] : 1'b0;
  endfunction

  assign err    = (len_q == '0) || (int'(len_q) > PAT_W);
  assign accept = q_valid && !err;

  // pb[j] is the j-th bit in arrival order (pattern bit len-1 arrives first)
  always_comb begin : reorder
    pb = '0;
    for (int j = 0; j < PAT_W; j++)
      if (j < int'(len_q)) pb[j] = pbit(pat_q, int'(len_q) - 1 - j);
  end

  // Longest proper border of the active pattern: resume point after an overlapped match
  always_comb begin : border_calc
    logic eq;
    eq     = 1'b0;
    border = '0;
    for (int b = 1; b < PAT_W; b++) begin
      eq = (b < int'(len_q));
      for (int i = 0; i < PAT_W - 1; i++)
        if (i < b) eq = eq && (pb[IDX_W'(i)] == pbit(pb, int'(len_q) - b + i));
      if (eq) border = LEN_W'(b);
    end
  end

  // Candidate prefix length: largest k such that prefix(k) is a suffix of prefix(s)+q
  always_comb begin : cand_calc
    logic ok;
    ok   = 1'b0;
    cand = '0;
    for (int k = 1; k <= PAT_W; k++) begin
      ok = (k <= int'(s_q) + 1) && (k <= int'(len_q)) && (pb[IDX_W'(k - 1)] == q);
      for (int i = 0; i < PAT_W - 1; i++)
        if (i < k - 1) ok = ok && (pb[IDX_W'(i)] == pbit(pb, int'(s_q) - k + 1 + i));
      if (ok) cand = LEN_W'(k);
    end
  end

  assign match = accept && (cand == len_q);

  always_comb begin
    s_d = s_q;
    if (match)       s_d = ovl_q ? border : '0;
    else if (accept) s_d = cand;
  end

  // A clear coinciding with a match restarts the count at one
  always_comb begin
    cnt_base = cnt_clr ? '0 : cnt_q;
    cnt_d    = cnt_q;
    if (match)        cnt_d = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
    else if (cnt_clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      s_q   <= '0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else if (cfg_load) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
      s_q   <= '0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      out_q <= match;
      cnt_q <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign progress    = s_q;
  assign cfg_err     = err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised bench for seq_detect_prog: history-queue reference model plus directed scenarios.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       reset, cfg_load, cfg_overlap, q_valid, q, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic       out1, err1, out2, err2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic [3:0] prog1, prog2;

  int total = 0;
  int bad   = 0;

  seq_detect_prog u_dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .q_valid(q_valid), .q(q),
    .cnt_clr(cnt_clr), .out(out1), .match_count(cnt1), .progress(prog1), .cfg_err(err1)
  );

  seq_detect_prog #(.PAT_W(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .q_valid(q_valid), .q(q),
    .cnt_clr(cnt_clr), .out(out2), .match_count(cnt2), .progress(prog2), .cfg_err(err2)
  );

  always #5 clk = ~clk;

  // Reference model: the accepted history itself, scanned for suffix/prefix equality
  logic [7:0] m_pat;
  int         m_len, m_cnt, m_cnt2, m_prog;
  bit         m_ovl, m_out, m_err;
  bit         hist[$];

  function automatic bit sfx_eq(int k);
    int n;
    n = hist.size();
    if (k == 0) return 1'b1;
    if (n < k) return 1'b0;
    for (int j = 0; j < k; j++)
      if (hist[n - k + j] != m_pat[m_len - 1 - j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit mt;
    int c;
    mt = 1'b0;
    if (!reset) begin
      m_pat = '0; m_len = 0; m_ovl = 0; m_out = 0; m_cnt = 0; m_cnt2 = 0;
      hist.delete();
    end else if (cfg_load) begin
      m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
      m_out = 0; m_cnt = 0; m_cnt2 = 0;
      hist.delete();
    end else begin
      if (q_valid && !m_err) begin
        hist.push_back(q);
        if (hist.size() > 8) void'(hist.pop_front());
        if (sfx_eq(m_len)) begin
          mt = 1'b1;
          if (!m_ovl) hist.delete();
        end
      end
      m_out = mt;
      if (mt) begin
        c = cnt_clr ? 0 : m_cnt;  if (c < 255) c++; m_cnt  = c;
        c = cnt_clr ? 0 : m_cnt2; if (c < 3)   c++; m_cnt2 = c;
      end else if (cnt_clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end
    end
    m_err  = (m_len == 0) || (m_len > 8);
    m_prog = 0;
    if (!m_err)
      for (int k = 1; k < m_len; k++)
        if (sfx_eq(k)) m_prog = k;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out",       32'(out1),  32'(m_out));
    chk("count",     32'(cnt1),  32'(m_cnt));
    chk("progress",  32'(prog1), 32'(m_prog));
    chk("cfg_err",   32'(err1),  32'(m_err));
    chk("out2",      32'(out2),  32'(m_out));
    chk("count2",    32'(cnt2),  32'(m_cnt2));
    chk("progress2", 32'(prog2), 32'(m_prog));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic feed(input bit b);
    q_valid = 1'b1; q = b;
    tick();
    q_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input int len, input bit ovl);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = 4'(len); cfg_overlap = ovl;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    int exp2[5];
    exp2 = '{1, 2, 3, 3, 3};
    reset = 0; cfg_load = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    q_valid = 0; q = 0; cnt_clr = 0;
    m_err = 1;
    tick(); tick();
    chk("rst out", 32'(out1), 0);
    chk("rst err", 32'(err1), 1);
    chk("rst cnt", 32'(cnt1), 0);
    reset = 1;

    // overlapping 1001 over 1001001
    load(8'h09, 4, 1'b1);
    feed(1); feed(0); feed(0); feed(1);
    chk("t1 out bit4", 32'(out1), 1);
    chk("t1 prog bit4", 32'(prog1), 1);
    feed(0); feed(0); feed(1);
    chk("t1 out bit7", 32'(out1), 1);
    chk("t1 cnt", 32'(cnt1), 2);
    chk("t1 model cnt", 32'(m_cnt), 2);
    chk("t1 prog bit7", 32'(prog1), 1);

    // non-overlapping
    load(8'h09, 4, 1'b0);
    feed(1); feed(0); feed(0); feed(1);
    chk("t2 out bit4", 32'(out1), 1);
    feed(0); feed(0); feed(1);
    chk("t2 out bit7", 32'(out1), 0);
    chk("t2 cnt", 32'(cnt1), 1);

    // valid gap holds progress
    load(8'h09, 4, 1'b1);
    feed(1); feed(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3 gap prog", 32'(prog1), 2);
    end
    feed(0);
    chk("t3 out early", 32'(out1), 0);
    feed(1);
    chk("t3 out", 32'(out1), 1);
    chk("t3 cnt", 32'(cnt1), 1);

    // len=1, back-to-back matches, 2-bit saturation
    load(8'h01, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      feed(1);
      chk("t4 out", 32'(out1), 1);
      chk("t4 cnt2", 32'(cnt2), 32'(exp2[i]));
    end
    cnt_clr = 1; feed(1); cnt_clr = 0;
    chk("t4 clr cnt2", 32'(cnt2), 1);
    chk("t4 clr cnt", 32'(cnt1), 1);
    chk("t4 model cnt2", 32'(m_cnt2), 1);

    // invalid length, then full-width pattern
    load(8'hFF, 0, 1'b1);
    chk("t5 err", 32'(err1), 1);
    for (int i = 0; i < 6; i++) feed(1'($urandom_range(0, 1)));
    chk("t5 cnt", 32'(cnt1), 0);
    load(8'hA5, 8, 1'b1);
    chk("t5 err clr", 32'(err1), 0);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) feed(a5[i]);
    chk("t5 out", 32'(out1), 1);
    chk("t5 cnt1", 32'(cnt1), 1);

    // reset mid-pattern
    load(8'h09, 4, 1'b1);
    feed(1); feed(0); feed(0);
    reset = 0; tick(); reset = 1;
    feed(1);
    chk("t6 out", 32'(out1), 0);
    chk("t6 prog", 32'(prog1), 0);
    chk("t6 cnt", 32'(cnt1), 0);
    chk("t6 err", 32'(err1), 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 199));
      reset    = (r != 0);
      cfg_load = (r >= 1 && r <= 4);
      if (cfg_load) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      q_valid = ($urandom_range(0, 4) != 0);
      q       = 1'($urandom_range(0, 1));
      cnt_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1; cfg_load = 0; q_valid = 0; cnt_clr = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
